uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serialises bytes onto a UART TX pin: 8N1 frame, LSB first, idle-high line.
//  Companion to the uart_rx receiver; same CLKS_PER_BIT timing and valid/ready handshake.
//  Sits between a byte producer (command/telemetry logic) and the FPGA TX pin.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200 baud); must be >= 2
//  PARITY_ODD    0    parity sense, used only with UART_TX_PARITY_EN: 0 = even, 1 = odd
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  synchronous reset, active-high
//  data_to_send  in   8  byte to transmit; sampled only on handshake
//  valid         in   1  producer has a byte (handshake)
//  ready         out  1  block can accept a byte (handshake)
//  tx            out  1  serial line, registered output
//  busy          out  1  frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: rst is synchronous, active-high; clock is clk. On rst: state=IDLE,
//    tx=1, count=0, bit_index=0. ready=1 and busy=0 from the first cycle after reset.
//  - ready = (state == IDLE); busy = ~ready. A transfer occurs on a posedge where
//    valid & ready. The byte is latched into a shift register on that edge.
//    valid while ready=0 is ignored. data_to_send changes mid-frame have no effect.
//  - FSM: IDLE -> START_BIT -> DATA_BITS -> [PARITY_BIT] -> STOP_BIT -> IDLE.
//    IDLE:       tx=1; on valid&ready -> START_BIT, count=0.
//    START_BIT:  tx=0 for CLKS_PER_BIT cycles; then -> DATA_BITS, bit_index=0.
//    DATA_BITS:  tx=byte[bit_index] for CLKS_PER_BIT cycles per bit, bit 0 first.
//                After bit 7 -> PARITY_BIT if enabled, else STOP_BIT.
//    PARITY_BIT: tx=parity for CLKS_PER_BIT cycles; then -> STOP_BIT.
//    STOP_BIT:   tx=1 for CLKS_PER_BIT cycles; then -> IDLE.
//  - count runs 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at each bit boundary.
//    bit_index is 3 bits wide and wraps 7->0 on leaving DATA_BITS.
//  - Cycle timing: let handshake edge be E0. tx=0 during cycles E0+1 .. E0+CLKS_PER_BIT.
//    Data bit i occupies the next CLKS_PER_BIT cycles, in order; the stop bit follows.
//    ready returns high in cycle E0+10*CLKS_PER_BIT+1 (11*CLKS_PER_BIT+1 with parity).
//  - Back-to-back: if valid is held high, the next handshake occurs in the first
//    IDLE cycle. Minimum handshake spacing is therefore 10*CLKS_PER_BIT+1 cycles
//    (+CLKS_PER_BIT with parity); the line is idle-high between frames for 1 cycle min.
//  - Reset mid-frame: the frame is abandoned. tx=1 and state=IDLE on the next cycle.
//    No byte is retained.
//  - valid and rst asserted together: rst wins and no transfer occurs.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: a PARITY_BIT state is inserted after bit 7.
//    parity = ^byte when PARITY_ODD=0 (even), ~^byte when PARITY_ODD=1 (odd).
//    Frame is 11 bits long.
//  UART_TX_PARITY_EN undefined: no parity state or logic; 8N1 frame of 10 bits.
//    PARITY_ODD is ignored.
// TESTING  (CLKS_PER_BIT=4 unless noted)
//  1. After reset: tx=1, ready=1, busy=0. Send 0x55 -> tx per 4-cycle bit:
//     0,1,0,1,0,1,0,1,0,1; ready=0 for exactly 40 cycles after the handshake.
//  2. valid held high with 0xA5 then 0x3C -> two frames. Handshakes 41 cycles apart.
//     Bits read LSB-first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
//  3. Change data_to_send and toggle valid mid-frame -> transmitted byte unchanged;
//     no extra handshake occurs.
//  4. rst asserted during bit 3 of 0xFF -> tx=1 and ready=1 the next cycle.
//     A following send of 0x00 produces a clean frame.
//  5. UART_TX_PARITY_EN, PARITY_ODD=0: 0x07 -> parity bit 1; 0x03 -> parity bit 0.
//     With PARITY_ODD=1 both are inverted. Frame is 44 cycles long.
//  6. Loopback into uart_rx (CLKS_PER_BIT=434): bytes 0x00, 0xFF, 0x5A, 0xC3
//     are received identically, in order.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frame, LSB first, idle-high line, valid/ready byte intake.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after bit 7.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_to_send,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [2:0]    r_bit_index;
  logic [7:0]    r_data;
  logic          r_tx;

  state_t        w_state_next;
  logic [CW-1:0] w_count_next;
  logic [2:0]    w_bit_index_next;
  logic [7:0]    w_data_next;
  logic          w_tx_next;
  logic          w_bit_end;

`ifdef UART_TX_PARITY_EN
  logic w_parity;
  assign w_parity = (PARITY_ODD != 0) ? ~^r_data : ^r_data;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign w_bit_end = (r_count == LAST_COUNT);

  // tx is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    w_state_next     = r_state;
    w_count_next     = w_bit_end ? '0 : r_count + 1'b1;
    w_bit_index_next = r_bit_index;
    w_data_next      = r_data;
    w_tx_next        = r_tx;
    case (r_state)
      S_IDLE: begin
        w_count_next = '0;
        w_tx_next    = 1'b1;
        if (valid) begin
          w_state_next = S_START;
          w_data_next  = data_to_send;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next     = S_DATA;
          w_bit_index_next = 3'd0;
          w_tx_next        = r_data[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bit_index_next = r_bit_index + 3'd1;
          if (r_bit_index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = w_parity;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_tx_next = r_data[w_bit_index_next];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_state_next = S_IDLE;
          w_tx_next    = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_bit_index <= 3'd0;
      r_data      <= 8'h00;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_bit_index <= w_bit_index_next;
      r_data      <= w_data_next;
      r_tx        <= w_tx_next;
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = ~ready;
  assign tx    = r_tx;

endmodule
